serial_multi_adder: RTL
=======================

Name: serial_multi_adder

Overview:
- Parametrised bit-serial multi-operand adder; successor to the fixed 3×32-bit serial adder datapath.
- Captures N_OPS operands of WIDTH bits on start.
- Adds them LSB-first, one result bit per enabled clock, using a multi-bit carry register.
- Presents the full-width sum in parallel with a one-cycle done pulse; feeds the result memories/readout logic.

Parameters:
- N_OPS, 3, number of operands summed (2..16)
- WIDTH, 32, operand width in bits (≥2)
- SUM_W (localparam), WIDTH+$clog2(N_OPS), result width; 34 at defaults
- CW (localparam), $clog2(N_OPS) (min 1), carry register width
- IW (localparam), $clog2(SUM_W), bit index width

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- CE  input  1  clock enable; when low all state holds
- start  input  1  request new addition; sampled only when not busy
- ops_in  input  N_OPS*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- busy  output  1  high while serial addition in progress
- done  output  1  one-cycle pulse, sum valid
- sum  output  SUM_W  result; holds until next accepted start completes
- bit_idx  output  IW  current bit position being processed (debug)

Behaviour:
- Reset (async, RESET=1): state=IDLE, busy=0, done=0, sum=0, bit_idx=0, carry=0, operand shift regs=0.
- All sequential updates are gated by CE=1. CE=0 freezes state, counters, shift regs, sum, busy and done (done stays high if frozen in DONE).
- States:
  - IDLE: start=1 at an enabled edge loads all operands into per-operand shift registers, clears carry and bit_idx → RUN, busy=1.
  - RUN: each enabled edge:
    - s = Σ(operand LSBs) + carry;
    - result bit = s[0], shifted into sum from the MSB side;
    - carry = s>>1;
    - operand shift regs shift right, fill per extension rule;
    - bit_idx++.
    - When bit_idx==SUM_W-1 at the edge → DONE.
  - DONE: done=1, busy=0 for exactly one enabled cycle. start=1 here is accepted exactly as in IDLE (→ RUN, back-to-back); otherwise → IDLE.
- Latency: the start-capture edge E0 is followed by SUM_W enabled edges of processing; done=1 in the cycle after the SUM_W-th edge (34 enabled cycles after E0 at defaults).
- Operand extension: bits beyond WIDTH feed 0 (unsigned).
- Carry bound: carry ≤ N_OPS-1 always; CW bits suffice; no overflow possible; sum is exact.
- start while busy (RUN): ignored, no queuing.
- ops_in changes after E0 do not affect the result.
- sum updates only at the final RUN edge. Intermediate shifting uses an internal register, so sum is stable from done until the next completion.
- RESET mid-RUN: immediate abort to reset values; no done pulse.
- X-free: all registers reset; no latches.

Optional Feature:
- Macro SERIAL_ADD_SIGNED_EN.
- Defined: operands are two's complement. Bits beyond WIDTH feed each operand's MSB (sign extension); sum is the exact SUM_W-bit two's-complement result. Latency and handshake are unchanged.
- Undefined: unsigned zero-extension as above.

Test Plan:
- Defaults, unsigned, all three operands 0xFFFF_FFFF, start 1 cycle → done exactly 34 cycles after capture, sum=0x2_FFFF_FFFD, busy high for 34 cycles.
- Operands 5, 7, 0x8000_0000; start held high for 40 cycles → first done at 34, sum=0x0_8000_000C; restart accepted in DONE cycle, second done 34 cycles later, same sum.
- start pulsed at cycle 10 of RUN with different ops_in, and ops_in changed mid-RUN → ignored; sum is that of the originally captured operands.
- CE=0 for 5 cycles mid-RUN → bit_idx frozen; done arrives at cycle 39 instead of 34; result correct.
- RESET asserted asynchronously at bit_idx=20 → outputs 0 immediately, no done; new start yields correct sum.
- SERIAL_ADD_SIGNED_EN defined, operands 0xFFFF_FFFF ×3 (−1 each) → sum=0x3_FFFF_FFFD (−3); N_OPS=4, WIDTH=8, operands 0x80 ×4 → sum=10'h200 (−512).

Source files
------------

// File: rtl/serial_multi_adder.sv
//------------------------------------------------------------------------------
// Module      : serial_multi_adder
// Description : Bit-serial multi-operand adder. N_OPS operands of WIDTH bits
//               are captured on start and summed LSB-first, one result bit per
//               enabled clock, with a multi-bit carry register. The full
//               SUM_W-bit sum is presented in parallel with a one-cycle done
//               pulse.
//
// Ports       : CLK     - system clock, rising edge
//               RESET   - asynchronous, active-high reset
//               CE      - clock enable; all state holds while low
//               start   - request a new addition (honoured in IDLE or DONE)
//               ops_in  - operand k at bits [k*WIDTH +: WIDTH]
//               busy    - high while the serial addition is running
//               done    - one-cycle pulse, sum valid
//               sum     - result; holds until the next addition completes
//               bit_idx - bit position currently being processed (debug)
//
// Options     : SERIAL_ADD_SIGNED_EN - when defined, operands are two's
//               complement and are sign-extended beyond WIDTH; otherwise they
//               are zero-extended (unsigned).
//
// Revision    : 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

module serial_multi_adder #(
  parameter int N_OPS = 3,
  parameter int WIDTH = 32,
  localparam int SUM_W = WIDTH + $clog2(N_OPS),
  localparam int CW    = ($clog2(N_OPS) < 1) ? 1 : $clog2(N_OPS),
  localparam int IW    = $clog2(SUM_W)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic                   start,
  input  logic [N_OPS*WIDTH-1:0] ops_in,
  output logic                   busy,
  output logic                   done,
  output logic [SUM_W-1:0]       sum,
  output logic [IW-1:0]          bit_idx
);

  // Column sum width: N_OPS operand bits plus a carry of at most N_OPS-1
  // never exceeds 2*N_OPS-1, which fits in CW+1 bits.
  localparam int            SW       = CW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SUM_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_ops [N_OPS];
  logic [CW-1:0]      r_carry;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_sum;
  logic [IW-1:0]      r_idx;
  logic               r_busy;
  logic               r_done;

  logic [SW-1:0]      w_s;
  logic [N_OPS-1:0]   w_fill;

  // Sum of the current operand LSBs plus the running carry.
  always_comb begin
    w_s = {1'b0, r_carry};
    for (int k = 0; k < N_OPS; k++) begin
      w_s = w_s + {{CW{1'b0}}, r_ops[k][0]};
    end
  end

  // Bit shifted into each operand's MSB once its own bits are consumed.
  // Replicating the MSB keeps feeding the sign bit indefinitely.
  always_comb begin
    w_fill = '0;
    for (int k = 0; k < N_OPS; k++) begin
`ifdef SERIAL_ADD_SIGNED_EN
      w_fill[k] = r_ops[k][WIDTH-1];
`else
      w_fill[k] = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      for (int k = 0; k < N_OPS; k++) begin
        r_ops[k] <= '0;
      end
      r_carry <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (CE) begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back
        // operation without an idle bubble.
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (start) begin
            for (int k = 0; k < N_OPS; k++) begin
              r_ops[k] <= ops_in[k*WIDTH +: WIDTH];
            end
            r_carry <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          for (int k = 0; k < N_OPS; k++) begin
            r_ops[k] <= {w_fill[k], r_ops[k][WIDTH-1:1]};
          end
          r_carry <= w_s[SW-1:1];
          // Result bits enter from the MSB side so that after SUM_W shifts
          // the first (LSB) result bit sits at position 0.
          r_acc   <= {w_s[0], r_acc[SUM_W-1:1]};
          r_idx   <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            // Only the final edge touches the visible sum, so it stays stable
            // while the next addition is in progress.
            r_sum   <= {w_s[0], r_acc[SUM_W-1:1]};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum     = r_sum;
  assign bit_idx = r_idx;

endmodule

`default_nettype wire
